i2s_frame_ctrl: RTL and testbench
=================================

// Module: i2s_frame_ctrl
// PURPOSE
//  Frame sequencer for the stereo i2s transmitter. Derives bclk (64x fs),
//  lrclk and the one-cycle sample-start strobe from the system clock.
//  Accepts stereo samples from the synth datapath over a valid/ready
//  handshake, stages one frame ahead and presents held L/R words to the
//  transmitter. Provides clean start/stop sequencing and underrun detection.
// PARAMETERS
//  BCLK_DIV  8   clk_i cycles per bclk period; even, >= 4
//  DATA_W    24  sample width, signed
// PORTS
//  clk_i        in   1       system clock, rising edge
//  rstn_i       in   1       reset, synchronous, active-low
//  en_i         in   1       run request; 1 = generate frames
//  s_valid_i    in   1       upstream sample pair valid
//  s_ready_o    out  1       staging register empty, can accept
//  s_left_i     in   DATA_W  left sample, signed
//  s_right_i    in   DATA_W  right sample, signed
//  bclk_o       out  1       bit clock to transmitter/codec
//  lrclk_o      out  1       0 = left slot, 1 = right slot
//  sampstart_o  out  1       1-cycle strobe at frame start
//  audio_l_o    out  DATA_W  held left word for current frame
//  audio_r_o    out  DATA_W  held right word for current frame
//  running_o    out  1       1 while in RUN or DRAIN
//  underrun_o   out  1       1-cycle pulse: frame started with staging empty
// BEHAVIOUR
//  Reset (rstn_i=0 at posedge): state=IDLE, div_cnt=0, bit_cnt=0, staging
//   empty; bclk_o=0, lrclk_o=0, sampstart_o=0, underrun_o=0, running_o=0,
//   audio_l_o=audio_r_o=0, s_ready_o=0 in the reset cycle, 1 after.
//  Reset mid-frame aborts immediately; no drain.
//  Counters: div_cnt 0..BCLK_DIV-1 wraps; bclk_o = (div_cnt >= BCLK_DIV/2),
//   registered. bit_cnt 0..63 advances on div_cnt wrap (bclk falling edge).
//   lrclk_o = bit_cnt[5]. Frame = 64*BCLK_DIV clk cycles.
//  FSM:
//   IDLE : counters held 0, bclk_o/lrclk_o low. en_i=1 -> RUN.
//   RUN  : counters free-run. en_i=0 -> DRAIN.
//   DRAIN: counters run to end of frame; at the wrap bit_cnt 63->0 go to
//          IDLE with no sampstart. en_i=1 in DRAIN -> RUN (no break).
//  Frame boundary = first RUN cycle after IDLE, or the cycle bit_cnt wraps
//   63->0 while staying in RUN. In that cycle sampstart_o=1 and:
//   - staging full: audio_l_o/audio_r_o <= staging, staging -> empty.
//   - staging empty: outputs hold previous words, underrun_o=1.
//  Handshake: transfer when s_valid_i & s_ready_o; s_ready_o = staging empty,
//   in any state incl. IDLE (prefill allowed). Transfer in a boundary cycle
//   fills staging for the NEXT frame; the current frame still underruns.
//   s_left_i/s_right_i sampled only on transfer.
//  Outputs audio_*_o change only in sampstart_o cycles.
//  running_o = (state != IDLE).
// CONFIGURATION
//  I2S_FRAME_UNDERRUN_CNT_EN defined: adds port underrun_cnt_o out 16,
//   saturating count of underrun_o pulses (stops at 16'hFFFF); cleared by
//   reset and on IDLE->RUN transition.
//  Not defined: port absent, no counter logic; all else identical.
// TESTING (BCLK_DIV=4, frame=256 clk)
//  Prefill (1,2) in IDLE, en_i=1 -> sampstart_o first RUN cycle,
//   audio_l_o=1, audio_r_o=2, underrun_o=0; next sampstart 256 cycles later.
//  Free-run: bclk_o period 4 clk, 50% duty; lrclk_o toggles every 128 clk,
//   low for bits 0-31.
//  No data after frame 0 -> underrun_o pulses with each sampstart, outputs
//   hold (1,2); with _EN counter reads 3 after 3 empty frames.
//  Valid in boundary cycle with staging empty -> underrun_o=1 that frame;
//   new pair appears at following sampstart.
//  en_i low at bit_cnt=10 -> frame completes, IDLE after bit 63, no extra
//   sampstart, bclk_o low, running_o=0.
//  rstn_i low at bit_cnt=40 -> next cycle all outputs at reset values,
//   staging empty, s_ready_o=1 after release.

Source files
------------

// File: rtl/i2s_frame_ctrl.sv
// Frame sequencer for the stereo I2S transmitter: bclk/lrclk generation, one-frame sample staging,
// start/stop sequencing and underrun detection. Define I2S_FRAME_UNDERRUN_CNT_EN to add underrun_cnt_o.
module i2s_frame_ctrl #(
    parameter int unsigned BCLK_DIV = 8,
    parameter int unsigned DATA_W   = 24
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_left_i,
    input  logic [DATA_W-1:0] s_right_i,
    output logic              bclk_o,
    output logic              lrclk_o,
    output logic              sampstart_o,
    output logic [DATA_W-1:0] audio_l_o,
    output logic [DATA_W-1:0] audio_r_o,
    output logic              running_o,
    output logic              underrun_o
`ifdef I2S_FRAME_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt_o
`endif
);

    localparam int unsigned DivW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax  = DivW'(BCLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(BCLK_DIV / 2);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [5:0]        bit_q, bit_d;
    logic              bclk_q;
    logic              full_q;
    logic              rst_done_q;
    logic [DATA_W-1:0] stage_l_q, stage_r_q;
    logic [DATA_W-1:0] audio_l_q, audio_r_q;

    logic div_wrap;
    logic frame_end;
    logic sampstart;
    logic ready;
    logic xfer;

    assign div_wrap  = (div_q == DivMax);
    assign frame_end = div_wrap && (bit_q == 6'd63);
    // Counters sit at zero in IDLE, so the first RUN cycle and every wrap share one test.
    assign sampstart = (state_q == StRun) && (div_q == '0) && (bit_q == '0);
    assign ready     = rst_done_q && !full_q;
    assign xfer      = s_valid_i && ready;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;

        if (state_q != StIdle) begin
            div_d = div_wrap ? '0 : div_q + DivW'(1);
            if (div_wrap) begin
                bit_d = bit_q + 6'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StRun;
            end
            StRun: begin
                if (!en_i) state_d = StDrain;
            end
            StDrain: begin
                if (en_i) begin
                    state_d = StRun;
                end else if (frame_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            bclk_q     <= 1'b0;
            full_q     <= 1'b0;
            rst_done_q <= 1'b0;
            stage_l_q  <= '0;
            stage_r_q  <= '0;
            audio_l_q  <= '0;
            audio_r_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            // Built from the next divider value so bclk_o tracks div_cnt without lag.
            bclk_q     <= (div_d >= DivHalf);
            rst_done_q <= 1'b1;

            if (xfer) begin
                full_q    <= 1'b1;
                stage_l_q <= s_left_i;
                stage_r_q <= s_right_i;
            end else if (sampstart && full_q) begin
                full_q <= 1'b0;
            end

            if (sampstart && full_q) begin
                audio_l_q <= stage_l_q;
                audio_r_q <= stage_r_q;
            end
        end
    end

    assign s_ready_o   = ready;
    assign bclk_o      = bclk_q;
    assign lrclk_o     = bit_q[5];
    assign sampstart_o = sampstart;
    assign audio_l_o   = audio_l_q;
    assign audio_r_o   = audio_r_q;
    assign running_o   = (state_q != StIdle);
    assign underrun_o  = sampstart && !full_q;

`ifdef I2S_FRAME_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ucnt_q <= '0;
        end else if ((state_q == StIdle) && (state_d == StRun)) begin
            ucnt_q <= '0;
        end else if (underrun_o && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt_o = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: a frame-phase model checked every cycle plus
// directed checks with hand-computed values (BCLK_DIV=4, 256 clk per frame).
module tb_i2s_frame_ctrl;

    localparam int unsigned BCLK_DIV = 4;
    localparam int unsigned DATA_W   = 24;
    localparam int          FRAME    = 64 * BCLK_DIV;

    logic              clk;
    logic              rstn;
    logic              en;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              bclk;
    logic              lrclk;
    logic              sampstart;
    logic [DATA_W-1:0] audio_l;
    logic [DATA_W-1:0] audio_r;
    logic              running;
    logic              underrun;
`ifdef I2S_FRAME_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    i2s_frame_ctrl #(
        .BCLK_DIV(BCLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .en_i       (en),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .s_left_i   (s_left),
        .s_right_i  (s_right),
        .bclk_o     (bclk),
        .lrclk_o    (lrclk),
        .sampstart_o(sampstart),
        .audio_l_o  (audio_l),
        .audio_r_o  (audio_r),
        .running_o  (running),
        .underrun_o (underrun)
`ifdef I2S_FRAME_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(underrun_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: mode 0=idle 1=run 2=drain; phase = clk position within the frame.
    int          m_mode = 0;
    int          m_phase = 0;
    bit          m_full = 0;
    bit          m_ok = 0;
    logic [DATA_W-1:0] m_sl = '0, m_sr = '0, m_al = '0, m_ar = '0;
    logic [15:0] m_cnt = '0;

    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            m_mode = 0; m_phase = 0; m_full = 0; m_ok = 0;
            m_sl = '0; m_sr = '0; m_al = '0; m_ar = '0; m_cnt = '0;
        end else begin
            bit ss, rdy, last;
            int old;
            ss  = (m_mode == 1) && (m_phase == 0);
            rdy = m_ok && !m_full;
            if (ss && !m_full && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_mode == 0 && en) m_cnt = '0;
            if (ss && m_full) begin
                m_al = m_sl; m_ar = m_sr; m_full = 0;
            end
            if (s_valid && rdy) begin
                m_full = 1; m_sl = s_left; m_sr = s_right;
            end
            old  = m_mode;
            last = (m_phase == FRAME - 1);
            if (old != 0) m_phase = (m_phase + 1) % FRAME;
            case (old)
                0: if (en) m_mode = 1;
                1: if (!en) m_mode = 2;
                default: begin
                    if (en) m_mode = 1;
                    else if (last) m_mode = 0;
                end
            endcase
            m_ok = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            bit e_ss;
            e_ss = (m_mode == 1) && (m_phase == 0);
            chk("m_bclk", 32'(bclk), 32'((m_phase % BCLK_DIV) >= BCLK_DIV / 2));
            chk("m_lrclk", 32'(lrclk), 32'((m_phase / (32 * BCLK_DIV)) % 2));
            chk("m_sampstart", 32'(sampstart), 32'(e_ss));
            chk("m_underrun", 32'(underrun), 32'(e_ss && !m_full));
            chk("m_ready", 32'(s_ready), 32'(m_ok && !m_full));
            chk("m_running", 32'(running), 32'(m_mode != 0));
            chk("m_audio_l", 32'(audio_l), 32'(m_al));
            chk("m_audio_r", 32'(audio_r), 32'(m_ar));
`ifdef I2S_FRAME_UNDERRUN_CNT_EN
            chk("m_ucnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic wait_ss(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sampstart && n < limit);
        chk("ss_found", 32'(sampstart), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        rstn = 1'b0; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        tick();
        chk_on = 1'b1;
        tick(); tick();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_ss", 32'(sampstart), 32'd0);
        chk("rst_audio_l", 32'(audio_l), 32'd0);

        rstn = 1'b1;
        tick();
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Prefill in IDLE
        s_valid = 1'b1; s_left = 24'd1; s_right = 24'd2;
        tick();
        s_valid = 1'b0;
        chk("prefill_ready", 32'(s_ready), 32'd0);
        chk("idle_running", 32'(running), 32'd0);

        en = 1'b1;
        tick();
        chk("f0_ss", 32'(sampstart), 32'd1);
        chk("f0_ur", 32'(underrun), 32'd0);
        chk("f0_running", 32'(running), 32'd1);
        tick();
        chk("f0_audio_l", 32'(audio_l), 32'd1);
        chk("f0_audio_r", 32'(audio_r), 32'd2);
        chk("bclk_ph1", 32'(bclk), 32'd0);
        tick();
        chk("bclk_ph2", 32'(bclk), 32'd1);
        repeat (125) tick();
        chk("lr_ph127", 32'(lrclk), 32'd0);
        tick();
        chk("lr_ph128", 32'(lrclk), 32'd1);

        wait_ss(300, n);
        chk("f1_period", 32'(n), 32'd128);
        chk("f1_ur", 32'(underrun), 32'd1);
        // Transfer in the boundary cycle feeds the next frame only.
        s_valid = 1'b1; s_left = 24'd3; s_right = 24'd4;
        tick();
        s_valid = 1'b0;
        chk("f1_hold_l", 32'(audio_l), 32'd1);
        chk("f1_hold_r", 32'(audio_r), 32'd2);
        chk("f1_ready", 32'(s_ready), 32'd0);

        wait_ss(300, n);
        chk("f2_period", 32'(n), 32'd255);
        chk("f2_ur", 32'(underrun), 32'd0);
        tick();
        chk("f2_audio_l", 32'(audio_l), 32'd3);
        chk("f2_audio_r", 32'(audio_r), 32'd4);

        wait_ss(300, n);
        chk("f3_period", 32'(n), 32'd255);
        chk("f3_ur", 32'(underrun), 32'd1);
        tick();
        chk("f3_hold_l", 32'(audio_l), 32'd3);

        // Stop request at bit 10 (phase 40)
        repeat (39) tick();
        en = 1'b0;
        seen = 0;
        repeat (215) begin
            tick();
            if (sampstart) seen++;
        end
        chk("drain_running", 32'(running), 32'd1);
        tick();
        if (sampstart) seen++;
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_bclk", 32'(bclk), 32'd0);
        chk("stop_lrclk", 32'(lrclk), 32'd0);
        chk("drain_no_ss", 32'(seen), 32'd0);
`ifdef I2S_FRAME_UNDERRUN_CNT_EN
        chk("ucnt_after_stop", 32'(underrun_cnt), 32'd2);
`endif

        // Reset mid-frame at bit 40 (phase 160)
        s_valid = 1'b1; s_left = 24'd5; s_right = 24'd6;
        tick();
        s_valid = 1'b0;
        en = 1'b1;
        tick();
        chk("r_ss", 32'(sampstart), 32'd1);
        chk("r_ur", 32'(underrun), 32'd0);
        tick();
        chk("r_audio_l", 32'(audio_l), 32'd5);
        s_valid = 1'b1; s_left = 24'd7; s_right = 24'd8;
        tick();
        s_valid = 1'b0;
        repeat (158) tick();
        chk("r_lr_ph160", 32'(lrclk), 32'd1);
        chk("r_running", 32'(running), 32'd1);
        rstn = 1'b0; en = 1'b0;
        tick();
        chk("mid_rst_running", 32'(running), 32'd0);
        chk("mid_rst_ss", 32'(sampstart), 32'd0);
        chk("mid_rst_ur", 32'(underrun), 32'd0);
        chk("mid_rst_bclk", 32'(bclk), 32'd0);
        chk("mid_rst_lrclk", 32'(lrclk), 32'd0);
        chk("mid_rst_audio_l", 32'(audio_l), 32'd0);
        chk("mid_rst_audio_r", 32'(audio_r), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        rstn = 1'b1;
        tick();
        chk("rel_ready", 32'(s_ready), 32'd1);
        chk("rel_running", 32'(running), 32'd0);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
